matrix_wb_arbiter: RTL
======================

# matrix_wb_arbiter

Two-master pipelined Wishbone arbiter that shares the single `matrix` framebuffer slave (8 words x 32 bits, byte-select) between `move_master` (master 0) and a second pixel source such as a serial loader (master 1). It sits between the masters and `matrix` in `top`. A master owns the bus for the whole of its `cyc` burst. Outstanding acknowledges are tracked so every ack is routed to the master that issued the strobe.

## Interface
Parameters:
- `AW`, 3, address width (matrix word index)
- `DW`, 32, data width; `SW = DW/8` byte selects
- `MAX_OUT`, 4, maximum accepted-but-unacked strobes (1..15)

Ports:
- `clk` in 1: single clock, all logic.
- `reset_n` in 1: reset, asynchronous and active-low.
- `i_m0_cyc`, `i_m0_stb`, `i_m0_we` in 1 each: master 0 request.
- `i_m0_addr` in AW, `i_m0_sel` in SW, `i_m0_wdata` in DW: master 0 request.
- `o_m0_ack`, `o_m0_stall` out 1 each, `o_m0_rdata` out DW: master 0 response.
- `i_m1_*` / `o_m1_*`: same set for master 1.
- `o_s_cyc`, `o_s_stb`, `o_s_we` out 1 each, `o_s_addr` out AW, `o_s_sel` out SW, `o_s_wdata` out DW: to slave.
- `i_s_ack`, `i_s_stall` in 1 each, `i_s_rdata` in DW: from slave.
- `o_grant` out 2: one-hot owner, for debug LEDs.

## Operation
- States: IDLE, OWN, DRAIN. Owner register `own` (0/1). `last` is the most recently granted master.
- IDLE:
  - No slave cyc/stb; both master stalls = 1.
  - If any `i_mX_cyc` is high, load `own` and go to OWN.
  - Both requesting: arbitration rule per Configuration.
- OWN:
  - `o_s_cyc` = 1; `o_s_stb` = owner stb AND (`cnt` < MAX_OUT).
  - we/addr/sel/wdata pass through from the owner.
  - Owner stall = `i_s_stall` OR (`cnt` == MAX_OUT).
  - Non-owner stall = 1, ack = 0.
  - When the owner's `cyc` falls: go to IDLE if `cnt` == 0, else go to DRAIN.
- DRAIN:
  - `o_s_cyc` = 1, `o_s_stb` = 0.
  - Acks still route to the former owner.
  - Both master stalls = 1.
  - Go to IDLE on the cycle `cnt` reaches 0, counting a decrement in the same cycle.
- Outstanding counter `cnt`, width `$clog2(MAX_OUT+1)`:
  - +1 on `o_s_stb & !i_s_stall`.
  - −1 on `i_s_ack`.
  - Both in the same cycle: unchanged.
  - Ack with `cnt` == 0: ignored, no underflow.
- `i_s_rdata` is fanned out to both masters unmodified. `o_mX_ack` = `i_s_ack` AND owner == X AND state != IDLE.
- Slave address/data/sel/we are forced to 0 in IDLE.

## Timing
- Reset values:
  - State IDLE, `own` = 0, `last` = 1, `cnt` = 0.
  - All `o_s_*` = 0, `o_mX_ack` = 0, `o_mX_stall` = 1, `o_grant` = 0.
- Grant latency: `cyc` sampled high at edge N. Owner drives the slave combinationally from cycle N+1, so the first strobe reaches the slave at N+1.
- Release:
  - Owner `cyc` low at edge N with `cnt` == 0: IDLE at N+1.
  - A new grant takes effect at N+2, giving one dead cycle between owners.
- The slave's stall and ack reach the owner combinationally, with zero added latency.
- Reset asserted mid-burst: immediately returns to reset values, no drain. Masters must treat it as an abort.

## Configuration
- `MATRIX_ARB_RR_EN` defined: round-robin. If both request in IDLE, grant `!last`.
- `MATRIX_ARB_RR_EN` undefined: fixed priority. Master 0 always wins a tie; `last` is still maintained but unused.
- Every other behaviour is identical in both builds.

## Structure
- Shared package `matrix_wb_pkg`:
  - `MATRIX_AW` = 3, `MATRIX_DW` = 32.
  - `typedef enum logic [1:0] {ARB_IDLE, ARB_OWN, ARB_DRAIN} arb_state_t`.
- No sub-module. Arbitration pick, counter and mux stay in one module (about 150–200 lines).

## Test plan
- Reset then idle:
  - Stimulus: hold `reset_n` = 0, release, no requests.
  - Required: all `o_s_*` = 0, both stalls = 1, `o_grant` = 2'b00.
- Single master 0 write:
  - Stimulus: cyc/stb, addr 3, sel 4'hF, wdata 32'h0707_0707.
  - Required: slave sees the write one cycle after cyc; ack returns to m0 only; IDLE one cycle after cyc falls.
- Tie in IDLE, both cyc high:
  - With RR: grants go m0, then m1, then m0 on successive bursts.
  - Without RR: m0 is granted every time.
- Back-pressure:
  - Stimulus: slave withholds acks for 4 accepted strobes (MAX_OUT = 4).
  - Required: 5th strobe stalled with `o_s_stb` = 0 until the first ack, then accepted.
- Drain:
  - Stimulus: m0 drops cyc with `cnt` = 2 while m1 is requesting.
  - Required: state DRAIN; 2 acks routed to m0 (not m1); m1 granted two cycles after `cnt` reaches 0.
- Async reset mid-burst:
  - Stimulus: `reset_n` low between clock edges during OWN.
  - Required: `o_s_cyc` drops without waiting for a clock edge; `cnt` = 0.

Source files
------------

// File: rtl/matrix_wb_pkg.sv
// Shared definitions for the matrix framebuffer Wishbone fabric.
package matrix_wb_pkg;

   localparam int MATRIX_AW = 3;
   localparam int MATRIX_DW = 32;

   typedef enum logic [1:0] {ARB_IDLE, ARB_OWN, ARB_DRAIN} arb_state_t;

endpackage

// File: rtl/matrix_wb_arbiter.sv
// Two-master pipelined Wishbone arbiter in front of the matrix framebuffer slave.
// Define MATRIX_ARB_RR_EN for round-robin tie breaking; otherwise master 0 wins ties.
module matrix_wb_arbiter
   import matrix_wb_pkg::*;
#(
   parameter int AW      = MATRIX_AW,
   parameter int DW      = MATRIX_DW,
   parameter int MAX_OUT = 4
)(
   input  logic              clk,
   input  logic              reset_n,

   input  logic              i_m0_cyc,
   input  logic              i_m0_stb,
   input  logic              i_m0_we,
   input  logic [AW-1:0]     i_m0_addr,
   input  logic [DW/8-1:0]   i_m0_sel,
   input  logic [DW-1:0]     i_m0_wdata,
   output logic              o_m0_ack,
   output logic              o_m0_stall,
   output logic [DW-1:0]     o_m0_rdata,

   input  logic              i_m1_cyc,
   input  logic              i_m1_stb,
   input  logic              i_m1_we,
   input  logic [AW-1:0]     i_m1_addr,
   input  logic [DW/8-1:0]   i_m1_sel,
   input  logic [DW-1:0]     i_m1_wdata,
   output logic              o_m1_ack,
   output logic              o_m1_stall,
   output logic [DW-1:0]     o_m1_rdata,

   output logic              o_s_cyc,
   output logic              o_s_stb,
   output logic              o_s_we,
   output logic [AW-1:0]     o_s_addr,
   output logic [DW/8-1:0]   o_s_sel,
   output logic [DW-1:0]     o_s_wdata,
   input  logic              i_s_ack,
   input  logic              i_s_stall,
   input  logic [DW-1:0]     i_s_rdata,

   output logic [1:0]        o_grant
);

   localparam int SW = DW / 8;
   localparam int CW = $clog2(MAX_OUT + 1);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);

   arb_state_t      r_state;
   arb_state_t      w_state_next;
   logic            r_own;
   logic            r_last;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_cnt_next;
   logic            w_own_cyc;
   logic            w_own_stb;
   logic            w_pick;
   logic            w_cnt_full;
   logic            w_inc;
   logic            w_dec;
   logic            w_any_req;

   assign w_any_req  = i_m0_cyc | i_m1_cyc;
   assign w_own_cyc  = r_own ? i_m1_cyc : i_m0_cyc;
   assign w_own_stb  = r_own ? i_m1_stb : i_m0_stb;
   assign w_cnt_full = (r_cnt == MAX_CNT);

`ifdef MATRIX_ARB_RR_EN
   assign w_pick = (i_m0_cyc & i_m1_cyc) ? ~r_last : i_m1_cyc;
`else
   assign w_pick = ~i_m0_cyc;
`endif

   // Acks arriving with nothing outstanding are dropped so the counter never wraps.
   assign w_inc = o_s_stb & ~i_s_stall;
   assign w_dec = i_s_ack & (r_cnt != '0);

   always_comb begin
      w_cnt_next = r_cnt;
      case ({w_inc, w_dec})
         2'b10:   w_cnt_next = r_cnt + 1'b1;
         2'b01:   w_cnt_next = r_cnt - 1'b1;
         default: w_cnt_next = r_cnt;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ARB_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ARB_IDLE: begin
            if (w_any_req) w_state_next = ARB_OWN;
         end
         ARB_OWN: begin
            if (!w_own_cyc) w_state_next = (r_cnt == '0) ? ARB_IDLE : ARB_DRAIN;
         end
         ARB_DRAIN: begin
            if (w_cnt_next == '0) w_state_next = ARB_IDLE;
         end
         default: w_state_next = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_own  <= 1'b0;
         r_last <= 1'b1;
         r_cnt  <= '0;
      end else begin
         if (r_state == ARB_IDLE && w_any_req) begin
            r_own  <= w_pick;
            r_last <= w_pick;
         end
         r_cnt <= w_cnt_next;
      end
   end

   assign o_m0_rdata = i_s_rdata;
   assign o_m1_rdata = i_s_rdata;

   // Payload reaches the slave only while a master owns the bus; otherwise it is held at zero.
   always_comb begin
      o_s_cyc    = 1'b0;
      o_s_stb    = 1'b0;
      o_s_we     = 1'b0;
      o_s_addr   = '0;
      o_s_sel    = '0;
      o_s_wdata  = '0;
      o_m0_stall = 1'b1;
      o_m1_stall = 1'b1;
      o_m0_ack   = 1'b0;
      o_m1_ack   = 1'b0;
      o_grant    = 2'b00;
      case (r_state)
         ARB_OWN: begin
            o_s_cyc = 1'b1;
            o_s_stb = w_own_stb & ~w_cnt_full;
            o_grant = r_own ? 2'b10 : 2'b01;
            if (r_own) begin
               o_s_we     = i_m1_we;
               o_s_addr   = i_m1_addr;
               o_s_sel    = i_m1_sel;
               o_s_wdata  = i_m1_wdata;
               o_m1_stall = i_s_stall | w_cnt_full;
            end else begin
               o_s_we     = i_m0_we;
               o_s_addr   = i_m0_addr;
               o_s_sel    = i_m0_sel;
               o_s_wdata  = i_m0_wdata;
               o_m0_stall = i_s_stall | w_cnt_full;
            end
         end
         ARB_DRAIN: begin
            o_s_cyc = 1'b1;
            o_grant = r_own ? 2'b10 : 2'b01;
         end
         default: begin
            o_s_cyc = 1'b0;
         end
      endcase
      if (r_state != ARB_IDLE) begin
         o_m0_ack = i_s_ack & ~r_own;
         o_m1_ack = i_s_ack &  r_own;
      end
   end

   logic [SW-1:0] w_unused_sw;
   assign w_unused_sw = '0;

endmodule
